// File: rtl/aether_engine_mem_stream_loader.sv
// Stream-to-memory loader: stages a 16-bit word stream in a FIFO and issues
// chunked WRITE tasks to the Aether Engine memory stage.
module aether_engine_mem_stream_loader #(
    parameter int unsigned ChunkWords = 16,
    parameter int unsigned FifoDepth  = 32,
    parameter int unsigned MaxAddr    = 33554430
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] word_count_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    input  logic [15:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [1:0]  mem_command_o,
    output logic [31:0] mem_start_address_o,
    output logic [31:0] mem_end_address_o,
    output logic [15:0] mem_data_write_o,
    input  logic        mem_data_write_done_i,
    input  logic        mem_task_finished_i,
    output logic [31:0] words_written_o
);
    localparam int unsigned     PtrW      = $clog2(FifoDepth);
    localparam int unsigned     OccW      = $clog2(FifoDepth + 1);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(FifoDepth - 1);
    localparam logic [OccW-1:0] FullOcc   = OccW'(FifoDepth);
    localparam logic [31:0]     Chunk32   = 32'(ChunkWords);
    localparam logic [32:0]     MaxAddr33 = 33'(MaxAddr);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_ISSUE, ST_GUARD, ST_WRITE, ST_NEXT
    } state_e;

    state_e          r_state, w_next_state;
    logic [15:0]     r_mem [FifoDepth];
    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
    logic [OccW-1:0] r_occ;
    logic [31:0]     r_addr, r_remaining, r_count, r_pushed, r_pop_cnt;
    logic [31:0]     r_words_written, r_start_addr, r_end_addr;
    logic            r_busy, r_done, r_error;

    logic            w_empty, w_full, w_push, w_pop_req, w_pop, w_abort, w_out_of_range;
    logic [31:0]     w_chunk, w_pop_total;
    logic [32:0]     w_last_addr;

    assign w_empty        = (r_occ == '0);
    assign w_full         = (r_occ == FullOcc);
    assign w_chunk        = (r_remaining < Chunk32) ? r_remaining : Chunk32;
    // Last touched address at 33 bits so a wrapping request counts as out of range.
    assign w_last_addr    = {1'b0, base_addr_i} + {1'b0, word_count_i} - 33'd1;
    assign w_out_of_range = (w_last_addr > MaxAddr33);

    assign s_ready_o   = r_busy && !w_full && (r_pushed < r_count);
    assign w_push      = s_valid_i && s_ready_o;
    assign w_pop_req   = (r_state == ST_WRITE) && mem_data_write_done_i && !w_empty;
    assign w_pop       = w_pop_req && !w_abort;
    assign w_pop_total = r_pop_cnt + {31'b0, w_pop_req};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE:  if (start_i && (word_count_i != '0) && !w_out_of_range) w_next_state = ST_FILL;
            ST_FILL:  if (32'(r_occ) >= w_chunk) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_GUARD;
            ST_GUARD: w_next_state = ST_WRITE;
            ST_WRITE: begin
                if ((mem_data_write_done_i && w_empty) ||
                    (mem_task_finished_i && (w_pop_total != w_chunk))) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (mem_task_finished_i) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT:  w_next_state = (r_remaining == w_chunk) ? ST_IDLE : ST_FILL;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // NOTE: the storage array is deliberately not reset; occupancy gates every read of it.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_count         <= '0;
            r_pushed        <= '0;
            r_pop_cnt       <= '0;
            r_words_written <= '0;
            r_start_addr    <= '0;
            r_end_addr      <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
                r_busy   <= 1'b0;
                r_error  <= 1'b1;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
                    r_pushed <= r_pushed + 32'd1;
                end
                if (w_pop) begin
                    r_rd_ptr        <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
                    r_pop_cnt       <= r_pop_cnt + 32'd1;
                    r_words_written <= r_words_written + 32'd1;
                end
                if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
                else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
            end

            case (r_state)
                ST_IDLE: if (start_i) begin
                    if (word_count_i == '0) begin
                        r_done          <= 1'b1;
                        r_error         <= 1'b0;
                        r_words_written <= '0;
                    end else if (w_out_of_range) begin
                        r_error <= 1'b1;
                    end else begin
                        r_addr          <= base_addr_i;
                        r_remaining     <= word_count_i;
                        r_count         <= word_count_i;
                        r_pushed        <= '0;
                        r_words_written <= '0;
                        r_error         <= 1'b0;
                        r_busy          <= 1'b1;
                    end
                end
                ST_FILL: if (w_next_state == ST_ISSUE) begin
                    r_start_addr <= r_addr;
                    r_end_addr   <= r_addr + w_chunk;
                    r_pop_cnt    <= '0;
                end
                ST_NEXT: begin
                    r_addr      <= r_addr + w_chunk;
                    r_remaining <= r_remaining - w_chunk;
                    if (w_next_state == ST_IDLE) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o              = r_busy;
    assign done_o              = r_done;
    assign error_o             = r_error;
    assign mem_command_o       = (r_state == ST_ISSUE) ? 2'd1 : 2'd0;
    assign mem_start_address_o = r_start_addr;
    assign mem_end_address_o   = r_end_addr;
    assign mem_data_write_o    = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign words_written_o     = r_words_written;
endmodule

// File: tb/tb_aether_engine_mem_stream_loader.sv
// Directed bench: stream feeder, memory-stage model and monitor run per transfer;
// each scenario task checks hand-computed addresses, data, cycles and flags.
module tb_aether_engine_mem_stream_loader;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] word_count_i = '0;
    logic        busy_o, done_o, error_o, s_ready_o;
    logic [15:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic [1:0]  mem_command_o;
    logic [31:0] mem_start_address_o, mem_end_address_o, words_written_o;
    logic [15:0] mem_data_write_o;
    logic        mem_data_write_done_i = 1'b0;
    logic        mem_task_finished_i = 1'b0;

    aether_engine_mem_stream_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .word_count_i(word_count_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .mem_command_o(mem_command_o), .mem_start_address_o(mem_start_address_o),
        .mem_end_address_o(mem_end_address_o), .mem_data_write_o(mem_data_write_o),
        .mem_data_write_done_i(mem_data_write_done_i),
        .mem_task_finished_i(mem_task_finished_i), .words_written_o(words_written_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           stop, timed_out;
    int           accepted, n_done, done_cyc, err_cyc;
    int           issue_cyc[$];
    logic [31:0]  issue_start[$];
    logic [31:0]  issue_end[$];
    logic [15:0]  wlog[$];
    logic [117:0] rst_snap;

    // Cycle c of a transfer is the negedge c cycles after start_i was driven.
    task automatic monitor(input int max_cyc);
        int cd = -1;
        for (int c = 1; c <= max_cyc && !stop; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
            if (mem_command_o == 2'd1) begin
                issue_cyc.push_back(c);
                issue_start.push_back(mem_start_address_o);
                issue_end.push_back(mem_end_address_o);
            end
            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (error_o === 1'b1 && err_cyc < 0) err_cyc = c;
            if (cd > 0) begin
                cd--;
                if (cd == 0) stop = 1;
            end else if (cd < 0 && (done_o === 1'b1 || error_o === 1'b1)) begin
                cd = 3;
            end
        end
        if (!stop) timed_out = 1;
        stop = 1;
    endtask

    task automatic feeder(input int offer, input logic [15:0] dbase, input int stall_at, input int stall_len);
        for (int c = 1; !stop; c++) begin
            @(negedge clk_i);
            if (stop) break;
            if (accepted < offer && !(c >= stall_at && c < stall_at + stall_len)) begin
                s_valid_i = 1'b1;
                s_data_i  = dbase + 16'(accepted);
                if (s_ready_o) accepted++;
            end else begin
                s_valid_i = 1'b0;
            end
        end
        s_valid_i = 1'b0;
    endtask

    // mode 0: normal; 1: finish after `limit` pops of the first chunk; 2: reset after `limit` pops.
    task automatic mem_model(input int mode, input int limit);
        int target;
        bit first = 1;
        while (!stop) begin
            @(negedge clk_i);
            if (stop) break;
            if (mem_command_o == 2'd1) begin
                target = (mode != 0 && first) ? limit : int'(mem_end_address_o - mem_start_address_o);
                if (target > 16 || target < 0) target = 16;
                first = 0;
                @(negedge clk_i);
                @(negedge clk_i);
                for (int p = 0; p < target; p++) begin
                    mem_data_write_done_i = 1'b1;
                    wlog.push_back(mem_data_write_o);
                    @(negedge clk_i);
                    mem_data_write_done_i = 1'b0;
                    if (p != target - 1) @(negedge clk_i);
                end
                if (mode == 2) begin
                    rst_ni = 1'b0;
                    @(negedge clk_i);
                    rst_snap = {busy_o, done_o, error_o, s_ready_o, mem_command_o, mem_start_address_o,
                                mem_end_address_o, mem_data_write_o, words_written_o};
                    rst_ni = 1'b1;
                    stop = 1;
                end else begin
                    mem_task_finished_i = 1'b1;
                    @(negedge clk_i);
                    mem_task_finished_i = 1'b0;
                end
            end
        end
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [31:0] count, input int offer,
                            input logic [15:0] dbase, input int stall_at, input int stall_len,
                            input int mode, input int limit);
        stop = 0; timed_out = 0; accepted = 0; n_done = 0; done_cyc = -1; err_cyc = -1;
        issue_cyc.delete(); issue_start.delete(); issue_end.delete(); wlog.delete();
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = base; word_count_i = count;
        fork
            monitor(400);
            feeder(offer, dbase, stall_at, stall_len);
            mem_model(mode, limit);
        join
        s_valid_i = 1'b0; mem_data_write_done_i = 1'b0; mem_task_finished_i = 1'b0;
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL xfer_timeout: base=%h count=%0d did not finish in 400 cycles", base, count); end
    endtask

    task automatic check_data(input string tag, input int n, input logic [15:0] dbase);
        n_cmp++; if (wlog.size() != n) begin n_bad++; $display("FAIL %s_write_count: got %0d want %0d", tag, wlog.size(), n); end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (i >= wlog.size() || wlog[i] !== dbase + 16'(i)) begin
                n_bad++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, (i < wlog.size()) ? wlog[i] : 16'hxxxx, dbase + 16'(i));
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        rst_snap = {busy_o, done_o, error_o, s_ready_o, mem_command_o, mem_start_address_o,
                    mem_end_address_o, mem_data_write_o, words_written_o};
        n_cmp++; if (rst_snap !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", rst_snap); end
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++; if ({busy_o, s_ready_o, mem_command_o} !== 4'b0) begin n_bad++; $display("FAIL reset_idle: got %b want 0000", {busy_o, s_ready_o, mem_command_o}); end
    endtask

    task automatic test_single_chunk();
        run_xfer(32'h100, 32'd16, 16, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (issue_cyc.size() != 1) begin n_bad++; $display("FAIL single_issue_count: got %0d want 1", issue_cyc.size()); end
        n_cmp++; if (issue_cyc.size() < 1 || issue_cyc[0] != 18) begin n_bad++; $display("FAIL single_issue_cycle: got %0d want 18", issue_cyc[0]); end
        n_cmp++; if (issue_start[0] !== 32'h100 || issue_end[0] !== 32'h110) begin n_bad++; $display("FAIL single_addr: got %h/%h want 100/110", issue_start[0], issue_end[0]); end
        check_data("single", 16, 16'h0000);
        n_cmp++; if (words_written_o !== 32'd16) begin n_bad++; $display("FAIL single_words_written: got %0d want 16", words_written_o); end
        n_cmp++; if (n_done != 1 || done_cyc != 53) begin n_bad++; $display("FAIL single_done: got %0d pulses at %0d want 1 at 53", n_done, done_cyc); end
        n_cmp++; if (busy_o !== 1'b0 || error_o !== 1'b0) begin n_bad++; $display("FAIL single_flags: got busy=%b err=%b want 0 0", busy_o, error_o); end
    endtask

    task automatic test_multi_chunk();
        logic [31:0] exp_s[3] = '{32'd0, 32'd16, 32'd32};
        logic [31:0] exp_e[3] = '{32'd16, 32'd32, 32'd40};
        run_xfer(32'h0, 32'd40, 41, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (issue_cyc.size() != 3) begin n_bad++; $display("FAIL multi_issue_count: got %0d want 3", issue_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= issue_start.size() || issue_start[i] !== exp_s[i] || issue_end[i] !== exp_e[i]) begin
                n_bad++; $display("FAIL multi_addr[%0d]: got %0d/%0d want %0d/%0d", i, issue_start[i], issue_end[i], exp_s[i], exp_e[i]);
            end
        end
        check_data("multi", 40, 16'h0000);
        n_cmp++; if (accepted != 40) begin n_bad++; $display("FAIL multi_accepted: got %0d want 40", accepted); end
        n_cmp++; if (n_done != 1 || done_cyc != 109) begin n_bad++; $display("FAIL multi_done: got %0d pulses at %0d want 1 at 109", n_done, done_cyc); end
        n_cmp++; if (words_written_o !== 32'd40) begin n_bad++; $display("FAIL multi_words_written: got %0d want 40", words_written_o); end
    endtask

    task automatic test_back_to_back();
        run_xfer(32'h300, 32'd32, 32, 16'h5000, 8, 5, 0, 0);
        n_cmp++; if (issue_cyc.size() != 2) begin n_bad++; $display("FAIL b2b_issue_count: got %0d want 2", issue_cyc.size()); end
        n_cmp++; if (issue_cyc[0] != 23) begin n_bad++; $display("FAIL b2b_first_issue_cycle: got %0d want 23", issue_cyc[0]); end
        n_cmp++; if (issue_cyc[1] != 59) begin n_bad++; $display("FAIL b2b_prefetch_issue_cycle: got %0d want 59", issue_cyc[1]); end
        n_cmp++; if (issue_start[1] !== 32'h310 || issue_end[1] !== 32'h320) begin n_bad++; $display("FAIL b2b_addr: got %h/%h want 310/320", issue_start[1], issue_end[1]); end
        check_data("b2b", 32, 16'h5000);
        n_cmp++; if (done_cyc != 94) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 94", done_cyc); end
    endtask

    task automatic test_zero_and_bounds();
        run_xfer(32'h40, 32'd0, 0, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (done_cyc != 1 || n_done != 1) begin n_bad++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 1", n_done, done_cyc); end
        n_cmp++; if (issue_cyc.size() != 0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL zero_no_issue: got issues=%0d busy=%b want 0 0", issue_cyc.size(), busy_o); end

        run_xfer(32'h1FFFFF0, 32'd32, 32, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (err_cyc != 1 || error_o !== 1'b1) begin n_bad++; $display("FAIL oor_error: got cycle %0d flag %b want 1 1", err_cyc, error_o); end
        n_cmp++; if (busy_o !== 1'b0 || issue_cyc.size() != 0 || n_done != 0 || accepted != 0) begin
            n_bad++; $display("FAIL oor_idle: got busy=%b issues=%0d done=%0d acc=%0d want 0 0 0 0", busy_o, issue_cyc.size(), n_done, accepted);
        end

        run_xfer(32'h1FFFFFB, 32'd4, 4, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (err_cyc != -1 || done_cyc != 17) begin n_bad++; $display("FAIL edge_ok: got err_cycle %0d done_cycle %0d want -1 17", err_cyc, done_cyc); end
        n_cmp++; if (issue_end[0] !== 32'h1FFFFFF) begin n_bad++; $display("FAIL edge_ok_end: got %h want 1ffffff", issue_end[0]); end

        run_xfer(32'h1FFFFFC, 32'd4, 4, 16'h0000, 0, 0, 0, 0);
        n_cmp++; if (err_cyc != 1 || issue_cyc.size() != 0) begin n_bad++; $display("FAIL edge_bad: got err_cycle %0d issues %0d want 1 0", err_cyc, issue_cyc.size()); end
    endtask

    task automatic test_protocol_error();
        run_xfer(32'h0, 32'd16, 16, 16'h0000, 0, 0, 1, 10);
        n_cmp++; if (err_cyc != 40) begin n_bad++; $display("FAIL proto_error_cycle: got %0d want 40", err_cyc); end
        n_cmp++; if (n_done != 0 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin n_bad++; $display("FAIL proto_idle: got done=%0d busy=%b rdy=%b want 0 0 0", n_done, busy_o, s_ready_o); end

        run_xfer(32'h40, 32'd16, 16, 16'h0A00, 0, 0, 0, 0);
        n_cmp++; if (err_cyc != -1 || error_o !== 1'b0) begin n_bad++; $display("FAIL proto_recover_error: got cycle %0d flag %b want -1 0", err_cyc, error_o); end
        n_cmp++; if (issue_start[0] !== 32'h40 || issue_end[0] !== 32'h50) begin n_bad++; $display("FAIL proto_recover_addr: got %h/%h want 40/50", issue_start[0], issue_end[0]); end
        check_data("proto_recover", 16, 16'h0A00);
        n_cmp++; if (done_cyc != 53) begin n_bad++; $display("FAIL proto_recover_done: got %0d want 53", done_cyc); end
    endtask

    task automatic test_reset_mid_write();
        run_xfer(32'h0, 32'd16, 16, 16'h0000, 0, 0, 2, 5);
        n_cmp++; if (rst_snap !== '0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", rst_snap); end
        n_cmp++; if (wlog.size() != 5 || n_done != 0) begin n_bad++; $display("FAIL midrst_writes: got %0d writes %0d done want 5 0", wlog.size(), n_done); end

        run_xfer(32'h200, 32'd4, 4, 16'h0B00, 0, 0, 0, 0);
        n_cmp++; if (issue_start[0] !== 32'h200 || issue_end[0] !== 32'h204) begin n_bad++; $display("FAIL midrst_next_addr: got %h/%h want 200/204", issue_start[0], issue_end[0]); end
        check_data("midrst_next", 4, 16'h0B00);
        n_cmp++; if (done_cyc != 17 || words_written_o !== 32'd4) begin n_bad++; $display("FAIL midrst_next_done: got cycle %0d words %0d want 17 4", done_cyc, words_written_o); end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_back_to_back();
        test_zero_and_bounds();
        test_protocol_error();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
